// File: rtl/mdu.sv
// Iterative unsigned shift-add multiply / restoring divide; n busy cycles then a one-cycle done pulse.
// No backpressure: start is honoured only in IDLE, ignored (not queued) while busy or done.
module mdu #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [3:0]   S,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] Z,
    output logic [n-1:0] Zhi,
    output logic         div_by_zero
);

    localparam int CW = $clog2(n + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [n-1:0]   hi_q, hi_d;     // mul: upper accumulator; div: partial remainder
    logic [n-1:0]   lo_q, lo_d;     // mul: multiplier/low product; div: dividend/quotient
    logic [n-1:0]   opb_q, opb_d;   // mul: multiplicand; div: divisor
    logic [n-1:0]   z_q, z_d, zhi_q, zhi_d;
    logic           dbz_q, dbz_d;

    logic [n:0]     mul_sum, div_trial;
    logic [n-1:0]   div_diff;
    logic [n-1:0]   mul_hi_nx, mul_lo_nx, div_rem_nx, div_quo_nx;
    logic           div_ge, last;

    always_comb begin
        mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        mul_hi_nx  = mul_sum[n:1];
        mul_lo_nx  = {mul_sum[0], lo_q[n-1:1]};
        // With a zero divisor every trial "fits", so the quotient fills with ones
        // and the dividend bits shift through unchanged into the remainder.
        div_trial  = {hi_q, lo_q[n-1]};
        div_ge     = div_trial >= {1'b0, opb_q};
        div_diff   = div_trial[n-1:0] - opb_q;
        div_rem_nx = div_ge ? div_diff : div_trial[n-1:0];
        div_quo_nx = {lo_q[n-2:0], div_ge};
        last       = (cnt_q == CW'(n - 1));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opb_d   = opb_q;
        z_d     = z_q;
        zhi_d   = zhi_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start && S == 4'b0010) begin
                    opb_d   = A;
                    lo_d    = B;
                    hi_d    = '0;
                    cnt_d   = '0;
                    state_d = MUL;
                end else if (start && S == 4'b0011) begin
                    opb_d   = B;
                    lo_d    = A;
                    hi_d    = '0;
                    cnt_d   = '0;
                    state_d = DIV;
                end
            end
            MUL: begin
                hi_d  = mul_hi_nx;
                lo_d  = mul_lo_nx;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    z_d     = mul_lo_nx;
                    zhi_d   = mul_hi_nx;
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DIV: begin
                hi_d  = div_rem_nx;
                lo_d  = div_quo_nx;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    z_d     = div_quo_nx;
                    zhi_d   = div_rem_nx;
                    dbz_d   = (opb_q == '0);
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opb_q   <= '0;
            z_q     <= '0;
            zhi_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opb_q   <= opb_d;
            z_q     <= z_d;
            zhi_q   <= zhi_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == MUL) || (state_q == DIV);
    assign done        = (state_q == DONE);
    assign Z           = z_q;
    assign Zhi         = zhi_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: random and directed mul/div ops, scoreboard checked by an independent monitor.
module tb_mdu;

    localparam int N = 32;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   S = 4'b0000;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic         busy, done, div_by_zero;
    logic [N-1:0] Z, Zhi;

    mdu #(.n(N)) dut (
        .clk(clk), .rst(rst), .start(start), .S(S), .A(A), .B(B),
        .busy(busy), .done(done), .Z(Z), .Zhi(Zhi), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] z;
        logic [N-1:0] zhi;
        logic         dbz;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    int   n_pushed = 0;
    int   n_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain unsigned arithmetic on the operands.
    function automatic exp_t model(input logic [3:0] s, input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t        r;
        logic [63:0] p;
        if (s == OP_MUL) begin
            p     = {32'b0, a} * {32'b0, b};
            r.z   = p[31:0];
            r.zhi = p[63:32];
            r.dbz = 1'b0;
        end else if (b == 0) begin
            r.z   = '1;
            r.zhi = a;
            r.dbz = 1'b1;
        end else begin
            r.z   = a / b;
            r.zhi = a % b;
            r.dbz = 1'b0;
        end
        return r;
    endfunction

    // Monitor: pops on every done and checks value, latency and busy length.
    initial begin : monitor
        int   busy_cnt;
        exp_t e;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_cnt = 0;
            end else begin
                if (busy) busy_cnt++;
                if (done) begin
                    n_done++;
                    if (exp_q.size() == 0) begin
                        check("done_unexpected", 64'(done), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("Z", 64'(Z), 64'(e.z));
                        check("Zhi", 64'(Zhi), 64'(e.zhi));
                        check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
                        check("latency", 64'(cyc - accept_cyc), 64'(N));
                        check("busy_cycles", 64'(busy_cnt), 64'(N));
                        check("busy_at_done", 64'(busy), 64'd0);
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int i = 0; i < N + 8 && !got; i++) begin
            @(negedge clk);
            got = done;
        end
        check("done_timeout", 64'(got), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [3:0] s, input logic [N-1:0] a, input logic [N-1:0] b);
        S = s; A = a; B = b; start = 1'b1;
        exp_q.push_back(model(s, a, b));
        n_pushed++;
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        start = 1'b0;
        A = $urandom;
        B = $urandom;
    endtask

    task automatic issue(input logic [3:0] s, input logic [N-1:0] a, input logic [N-1:0] b);
        launch(s, a, b);
        wait_done();
    endtask

    initial begin : stim
        logic [N-1:0] ra, rb;
        int           activity;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_Z", 64'(Z), 64'd0);
        check("rst_Zhi", 64'(Zhi), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(OP_MUL, 32'd7, 32'd6);
        issue(OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF);
        issue(OP_DIV, 32'd100, 32'd7);
        issue(OP_DIV, 32'd5, 32'd9);
        issue(OP_DIV, 32'h1234, 32'd0);
        issue(OP_MUL, 32'd3, 32'd3);

        // Unsupported op: no busy, no done, result registers untouched.
        S = 4'b0100; A = 32'd11; B = 32'd13; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        activity = 0;
        for (int i = 0; i < N + 4; i++) begin
            @(negedge clk);
            if (busy || done) activity++;
        end
        check("bad_op_activity", 64'(activity), 64'd0);
        check("bad_op_Z_held", 64'(Z), 64'd9);
        @(posedge clk);
        #1;

        // Second start mid-operation must be ignored.
        launch(OP_MUL, 32'd1234, 32'd5678);
        repeat (9) @(posedge clk);
        #1;
        S = OP_MUL; A = 32'd99; B = 32'd99; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();

        // Abort a div with reset: outputs clear at once and no done follows.
        issue(OP_DIV, 32'hABCD, 32'd0);
        S = OP_DIV; A = 32'd99; B = 32'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_Z", 64'(Z), 64'd0);
        check("abort_Zhi", 64'(Zhi), 64'd0);
        check("abort_dbz", 64'(div_by_zero), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (N + 4) @(negedge clk);
        @(posedge clk);
        #1;
        issue(OP_MUL, 32'd2, 32'd3);

        // Random mix with edge-leaning operands.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = $urandom_range(0, 15);
                2: rb = 0;
                default: rb = ra;
            endcase
            if ($urandom_range(0, 5) == 0) ra = $urandom_range(0, 3);
            issue(($urandom_range(0, 1) != 0) ? OP_MUL : OP_DIV, ra, rb);
        end

        repeat (3) @(posedge clk);
        check("done_count", 64'(n_done), 64'(n_pushed));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
